// File: rtl/pump_scheduler.sv
// pump_scheduler: runs one of three scent pumps in a repeating spray/pause
// cycle for a latched session length (30/60/120 minutes). Counting starts on
// a valid pump_on strobe. The session ends when the timer expires, in which
// case done pulses, or when pump_off arrives.
//
// Optional feature: define PUMP_SCHED_LOCKOUT_EN to add a restart lockout
// after pump_off. While locked out, pump_on is ignored for LOCKOUT_SEC
// seconds and the FSM then returns to IDLE.
//
// Handshake: pump_on and pump_off are single-cycle strobes sampled on the
// rising clock edge. There is no back-pressure. All outputs are registered
// and show the state entered on that edge.
module pump_scheduler #(
    parameter int TICKS_PER_SEC = 1_000_000,
    parameter int SPRAY_SEC     = 3,
    parameter int CYCLE_SEC     = 60,
`ifdef PUMP_SCHED_LOCKOUT_EN
    parameter int SEC_PER_MIN   = 60,
    parameter int LOCKOUT_SEC   = 5
`else
    parameter int SEC_PER_MIN   = 60
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pump_on,
    input  logic       pump_off,
    input  logic [1:0] scent_sel,
    input  logic [1:0] timer_sel,
    output logic [2:0] pump_en,
    output logic       busy,
    output logic [6:0] remaining_min,
    output logic [1:0] active_scent,
    output logic       done
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int CW = (CYCLE_SEC > 1) ? $clog2(CYCLE_SEC) : 1;
    localparam int MW = (SEC_PER_MIN > 1) ? $clog2(SEC_PER_MIN) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
    localparam logic [CW-1:0] CYC_LAST   = CW'(CYCLE_SEC - 1);
    localparam logic [CW-1:0] SPRAY_END  = CW'(SPRAY_SEC);
    localparam logic [MW-1:0] MIN_LAST   = MW'(SEC_PER_MIN - 1);

`ifdef PUMP_SCHED_LOCKOUT_EN
    localparam int LW = (LOCKOUT_SEC > 1) ? $clog2(LOCKOUT_SEC) : 1;
    localparam logic [LW-1:0] LOCK_LAST = LW'(LOCKOUT_SEC - 1);
`endif

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SPRAY   = 2'd1,
`ifdef PUMP_SCHED_LOCKOUT_EN
        ST_PAUSE   = 2'd2,
        ST_LOCKOUT = 2'd3
`else
        ST_PAUSE   = 2'd2
`endif
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [PW-1:0] presc_q;
    logic [CW-1:0] cyc_sec_q;
    logic [MW-1:0] min_sec_q;
    logic [CW-1:0] cyc_next;
`ifdef PUMP_SCHED_LOCKOUT_EN
    logic [LW-1:0] lock_sec_q;
    logic          lock_done;
`endif

    logic       running;
    logic       sel_valid;
    logic       sec_tick;
    logic       min_wrap;
    logic       start;
    logic       stop;
    logic       expire;
    logic       clear_cnt;
    logic [6:0] reload_min;

    logic [2:0] pump_en_d;
    logic       busy_d;
    logic [6:0] remaining_d;
    logic [1:0] scent_d;
    logic       done_d;

    // Event decode shared by the next-state and output logic.
    always_comb begin
        running   = (state_q == ST_SPRAY) || (state_q == ST_PAUSE);
        sel_valid = (scent_sel != 2'd3);
        sec_tick  = (state_q != ST_IDLE) && (presc_q == PRESC_LAST);
        min_wrap  = sec_tick && (min_sec_q == MIN_LAST);
        cyc_next  = (cyc_sec_q == CYC_LAST) ? '0 : cyc_sec_q + 1'b1;
        // pump_off takes priority over pump_on; LOCKOUT is not a start-capable state
        start     = pump_on && sel_valid && !pump_off &&
                    ((state_q == ST_IDLE) || running);
        stop      = pump_off && running;
        // a restart on the expiry tick takes priority over expiry
        expire    = running && !stop && !start && min_wrap &&
                    (remaining_min == 7'd1);
`ifdef PUMP_SCHED_LOCKOUT_EN
        lock_done = (state_q == ST_LOCKOUT) && sec_tick && (lock_sec_q == LOCK_LAST);
`endif
        case (timer_sel)
            2'd1:    reload_min = 7'd60;
            2'd2:    reload_min = 7'd120;
            default: reload_min = 7'd30;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: start/restart, stop, expiry, then spray/pause phase on each second.
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = ST_SPRAY;
        end else if (stop) begin
`ifdef PUMP_SCHED_LOCKOUT_EN
            state_d = ST_LOCKOUT;
`else
            state_d = ST_IDLE;
`endif
        end else if (expire) begin
            state_d = ST_IDLE;
        end else if (running && sec_tick) begin
            state_d = (cyc_next < SPRAY_END) ? ST_SPRAY : ST_PAUSE;
`ifdef PUMP_SCHED_LOCKOUT_EN
        end else if (lock_done) begin
            state_d = ST_IDLE;
`endif
        end
    end

    // Output logic: values the output registers take on this edge, derived from state_d.
    always_comb begin
        scent_d   = start ? scent_sel : active_scent;
        busy_d    = (state_d == ST_SPRAY) || (state_d == ST_PAUSE);
        pump_en_d = (state_d == ST_SPRAY) ? (3'b001 << scent_d) : 3'b000;
        done_d    = expire;
        if (start) begin
            remaining_d = reload_min;
        end else if (!busy_d) begin
            remaining_d = 7'd0;
        end else if (min_wrap) begin
            remaining_d = remaining_min - 7'd1;
        end else begin
            remaining_d = remaining_min;
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pump_en       <= 3'b000;
            busy          <= 1'b0;
            remaining_min <= 7'd0;
            active_scent  <= 2'd0;
            done          <= 1'b0;
        end else begin
            pump_en       <= pump_en_d;
            busy          <= busy_d;
            remaining_min <= remaining_d;
            active_scent  <= scent_d;
            done          <= done_d;
        end
    end

    // Counters restart on a start, when the session stops, and when it returns to IDLE.
    always_comb begin
        clear_cnt = (state_d == ST_IDLE) || stop;
    end

    // Timebase: prescaler -> seconds within the spray cycle and within the current minute.
    always_ff @(posedge clk) begin
        if (reset || start || clear_cnt) begin
            presc_q    <= '0;
            cyc_sec_q  <= '0;
            min_sec_q  <= '0;
`ifdef PUMP_SCHED_LOCKOUT_EN
            lock_sec_q <= '0;
`endif
        end else if (state_q != ST_IDLE) begin
            if (sec_tick) begin
                presc_q   <= '0;
                cyc_sec_q <= cyc_next;
                min_sec_q <= (min_sec_q == MIN_LAST) ? '0 : min_sec_q + 1'b1;
`ifdef PUMP_SCHED_LOCKOUT_EN
                if (state_q == ST_LOCKOUT) begin
                    lock_sec_q <= lock_sec_q + 1'b1;
                end
`endif
            end else begin
                presc_q <= presc_q + 1'b1;
            end
        end
    end

endmodule
